// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave register port.
package spi_pkg;

    localparam int FRAME_BITS = 32;
    localparam int ADDR_BITS  = 16;
    localparam int SPI_MODE   = 3;

    // Clock polarity of the selected SPI mode: mode 2/3 idle high.
    localparam logic SCLK_IDLE = 1'(SPI_MODE >> 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4,
        ST_WAIT_HI = 3'd5
    } spi_state_t;

    function automatic logic [7:0] shift_in(input logic [7:0] cur,
                                            input logic       bit_in,
                                            input logic       lsb_first);
        return lsb_first ? {bit_in, cur[7:1]} : {cur[6:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line, with
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk40M,
    input  logic nRst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_q    = r_sync[SYNC_STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_slave_reg_port.sv
// SPI mode-3 slave that turns 32-bit frames into register write strobes
// and shifts register read-back data out on MISO during the data phase.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus idle, waiting for chip-select falling edge
// ADDR    | receiving bits 0-15 (address)
// DATA    | receiving bits 16-31 (data), read-back driven on MISO
// DONE    | full frame received, waiting for chip-select high
// ERR     | extra clock seen after a full frame, waiting for chip-select high
// WAIT_HI | after reset, waiting for an idle bus before accepting frames
module spi_slave_reg_port
    import spi_pkg::*;
#(
    parameter int LSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk40M,
    input  logic        nRst,
    input  logic        spi_clk,
    input  logic        sl,
    input  logic        mosi,
    output logic        miso,
    output logic        o_wr_en,
    output logic [15:0] o_addr,
    output logic [15:0] o_wr_data,
    output logic        o_rd_req,
    input  logic [15:0] i_rd_data,
    output logic        o_frame_err
);

    localparam logic LSB = (LSB_FIRST != 0);

    logic       w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic       w_sl_sync, w_sl_rise, w_sl_fall;
    logic       w_mosi, w_sample;
    logic [7:0] w_byte_next;

    spi_state_t r_state, w_state_next;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [5:0]  r_cnt;
    logic [3:0]  r_settle;
    logic [7:0]  r_byte, r_byte0, r_byte2;
    logic [15:0] r_miso_sr;
    logic        r_miso, r_cap;

    logic w_clr_cnt, w_shift, w_addr_load, w_wr_load, w_err, w_miso_shift;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk_sync (
        .clk40M (clk40M),
        .nRst   (nRst),
        .i_d    (spi_clk),
        .o_q    (w_sclk_sync),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sl_sync (
        .clk40M (clk40M),
        .nRst   (nRst),
        .i_d    (sl),
        .o_q    (w_sl_sync),
        .o_rise (w_sl_rise),
        .o_fall (w_sl_fall)
    );

    // Same depth as the clock synchronizer so data lines up with the rise pulse.
    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
        end
    end

    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sample    = w_sclk_rise & ~w_sl_sync;
    assign w_byte_next = shift_in(r_byte, w_mosi, LSB);

    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            r_state <= ST_WAIT_HI;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_sl_fall) w_state_next = ST_ADDR;
            ST_ADDR: begin
                if (w_sl_rise)
                    w_state_next = ST_IDLE;
                else if (w_sample && r_cnt == 6'(ADDR_BITS - 1))
                    w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_sl_rise)
                    w_state_next = ST_IDLE;
                else if (w_sample && r_cnt == 6'(FRAME_BITS - 1))
                    w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (w_sl_rise)
                    w_state_next = ST_IDLE;
                else if (w_sample)
                    w_state_next = ST_ERR;
            end
            ST_ERR:     if (w_sl_rise) w_state_next = ST_IDLE;
            ST_WAIT_HI: begin
                if (r_settle == 4'd0 && w_sl_sync && w_sclk_sync == SCLK_IDLE)
                    w_state_next = ST_IDLE;
            end
            default:    w_state_next = ST_WAIT_HI;
        endcase
    end

    always_comb begin
        w_clr_cnt    = (r_state == ST_IDLE) && w_sl_fall;
        w_shift      = ((r_state == ST_ADDR) || (r_state == ST_DATA)) && w_sample;
        w_addr_load  = (r_state == ST_ADDR) && w_sample && (r_cnt == 6'(ADDR_BITS - 1));
        w_wr_load    = (r_state == ST_DATA) && w_sample && (r_cnt == 6'(FRAME_BITS - 1));
        w_err        = ((r_state == ST_ADDR) || (r_state == ST_DATA) ||
                        (r_state == ST_ERR)) && w_sl_rise;
        w_miso_shift = (r_state == ST_DATA) && w_sclk_fall;
    end

    always_ff @(posedge clk40M or negedge nRst) begin
        if (!nRst) begin
            r_cnt       <= '0;
            r_settle    <= 4'(SYNC_STAGES);
            r_byte      <= '0;
            r_byte0     <= '0;
            r_byte2     <= '0;
            o_addr      <= '0;
            o_wr_data   <= '0;
            o_wr_en     <= 1'b0;
            o_rd_req    <= 1'b0;
            o_frame_err <= 1'b0;
            r_cap       <= 1'b0;
            r_miso_sr   <= '0;
            r_miso      <= 1'b0;
        end else begin
            o_wr_en     <= w_wr_load;
            o_rd_req    <= w_addr_load;
            o_frame_err <= w_err;
            r_cap       <= o_rd_req;

            // Lets stale reset-value synchronizer contents drain before trusting sl.
            if (r_state == ST_WAIT_HI && r_settle != 4'd0)
                r_settle <= r_settle - 4'd1;

            if (w_clr_cnt) begin
                r_cnt  <= '0;
                r_miso <= 1'b0;
            end else if (w_shift) begin
                r_cnt  <= r_cnt + 6'd1;
                r_byte <= w_byte_next;
                if (r_cnt == 6'd7)
                    r_byte0 <= w_byte_next;
                if (r_cnt == 6'd23)
                    r_byte2 <= w_byte_next;
            end

            if (w_addr_load)
                o_addr <= {w_byte_next, r_byte0};
            if (w_wr_load)
                o_wr_data <= {w_byte_next, r_byte2};

            // MSB-first mode sends the low byte first, so swap bytes on capture.
            if (r_cap) begin
                r_miso_sr <= LSB ? i_rd_data : {i_rd_data[7:0], i_rd_data[15:8]};
            end else if (w_miso_shift) begin
                r_miso    <= LSB ? r_miso_sr[0] : r_miso_sr[15];
                r_miso_sr <= LSB ? {1'b0, r_miso_sr[15:1]} : {r_miso_sr[14:0], 1'b0};
            end
        end
    end

    assign miso = (r_state == ST_DATA) && r_miso;

endmodule

// File: tb/tb_spi_slave_reg_port.sv
// Randomized mode-3 SPI master bench for spi_slave_reg_port with a
// frame-level reference model of writes, errors and read-back.
module tb_spi_slave_reg_port;

    logic        clk40M = 1'b0;
    logic        nRst = 1'b0;
    logic        spi_clk = 1'b1;
    logic        sl = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        o_wr_en;
    logic [15:0] o_addr;
    logic [15:0] o_wr_data;
    logic        o_rd_req;
    logic [15:0] i_rd_data = 16'h0000;
    logic        o_frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    int err_cnt  = 0;
    int rd_cnt   = 0;
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    spi_slave_reg_port dut (
        .clk40M      (clk40M),
        .nRst        (nRst),
        .spi_clk     (spi_clk),
        .sl          (sl),
        .mosi        (mosi),
        .miso        (miso),
        .o_wr_en     (o_wr_en),
        .o_addr      (o_addr),
        .o_wr_data   (o_wr_data),
        .o_rd_req    (o_rd_req),
        .i_rd_data   (i_rd_data),
        .o_frame_err (o_frame_err)
    );

    always #5 clk40M = ~clk40M;

    function automatic logic [15:0] rd_model(input logic [15:0] a);
        return (a == 16'h0030) ? 16'hA5C3 : ({a[7:0], a[15:8]} ^ 16'h5AA5);
    endfunction

    // Register file stand-in: data valid the cycle after the request.
    always @(posedge clk40M) begin
        if (o_rd_req) i_rd_data <= rd_model(o_addr);
    end

    always @(negedge clk40M) begin
        if (o_wr_en) begin
            wr_cnt++;
            wr_addr_q.push_back(o_addr);
            wr_data_q.push_back(o_wr_data);
        end
        if (o_frame_err) err_cnt++;
        if (o_rd_req) rd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk40M);
    endtask

    task automatic spi_bit(input logic b, input int h, output logic m);
        spi_clk = 1'b0;
        mosi    = b;
        wait_cyc(h);
        spi_clk = 1'b1;
        m       = miso;
        wait_cyc(h);
    endtask

    // Clocks bits [first, last) of the frame word, LSB first; collects read-back.
    task automatic spi_bits(input logic [31:0] w, input int first, input int last,
                            input int h, inout logic [15:0] rb);
        logic m;
        logic b;
        for (int i = first; i < last; i++) begin
            b = (i < 32) ? w[i] : 1'($urandom);
            spi_bit(b, h, m);
            if (i >= 16 && i < 32) rb[i-16] = m;
        end
    endtask

    task automatic run_frame(input logic [15:0] a, input logic [15:0] d, input int nbits,
                             input int h, input int gap, output logic [15:0] rb);
        rb = 16'h0000;
        wait_cyc(1);
        sl = 1'b0;
        wait_cyc(h);
        spi_bits({d, a}, 0, nbits, h, rb);
        wait_cyc(h);
        sl = 1'b1;
        wait_cyc(gap);
    endtask

    // Expected outcome derives only from how many bits the master clocked.
    task automatic frame_check(input string tag, input logic [15:0] a, input logic [15:0] d,
                               input int nbits, input int h);
        int wr0, err0, rd0;
        logic [15:0] rb;
        wr0 = wr_cnt; err0 = err_cnt; rd0 = rd_cnt;
        run_frame(a, d, nbits, h, 12, rb);
        check({tag, "_wr_cnt"},  32'(wr_cnt - wr0),  (nbits >= 32) ? 32'd1 : 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt - err0), (nbits != 32) ? 32'd1 : 32'd0);
        check({tag, "_rd_cnt"},  32'(rd_cnt - rd0),  (nbits >= 16) ? 32'd1 : 32'd0);
        if (nbits >= 32) begin
            if (wr_addr_q.size() > 0) begin
                check({tag, "_addr"}, 32'(wr_addr_q.pop_front()), 32'(a));
                check({tag, "_data"}, 32'(wr_data_q.pop_front()), 32'(d));
            end else begin
                check({tag, "_wr_queue"}, 32'd0, 32'd1);
            end
            check({tag, "_readback"}, 32'(rb), 32'(rd_model(a)));
        end
        if (nbits >= 16) check({tag, "_addr_hold"}, 32'(o_addr), 32'(a));
        check({tag, "_miso_idle"}, 32'(miso), 32'd0);
    endtask

    initial begin
        logic [15:0] rb;
        logic [15:0] ra[10];
        logic [15:0] rd[10];
        int wr0, err0, rd0;
        int lens[5];
        lens[0] = 12; lens[1] = 20; lens[2] = 32; lens[3] = 32; lens[4] = 33;

        wait_cyc(3);
        check("rst_miso",      32'(miso), 32'd0);
        check("rst_wr_en",     32'(o_wr_en), 32'd0);
        check("rst_rd_req",    32'(o_rd_req), 32'd0);
        check("rst_frame_err", 32'(o_frame_err), 32'd0);
        check("rst_addr",      32'(o_addr), 32'd0);
        check("rst_wr_data",   32'(o_wr_data), 32'd0);
        nRst = 1'b1;
        wait_cyc(10);

        frame_check("basic",    16'h00F9, 16'hC007, 32, 8);
        frame_check("readback", 16'h0030, 16'h1234, 32, 8);
        frame_check("short20",  16'h1357, 16'h2468, 20, 6);
        frame_check("after20",  16'h0102, 16'h0304, 32, 6);
        frame_check("clk33",    16'hBEEF, 16'h0F0F, 33, 5);

        // Reset mid-frame, released with chip select still low.
        wr0 = wr_cnt; err0 = err_cnt; rd0 = rd_cnt;
        rb = 16'h0000;
        sl = 1'b0;
        wait_cyc(6);
        spi_bits({16'hAAAA, 16'h5555}, 0, 10, 6, rb);
        nRst = 1'b0;
        wait_cyc(3);
        check("midrst_addr", 32'(o_addr), 32'd0);
        check("midrst_miso", 32'(miso), 32'd0);
        nRst = 1'b1;
        wait_cyc(6);
        spi_bits({16'hAAAA, 16'h5555}, 10, 32, 6, rb);
        wait_cyc(6);
        check("midrst_wr_low",  32'(wr_cnt - wr0), 32'd0);
        check("midrst_err_low", 32'(err_cnt - err0), 32'd0);
        check("midrst_rd_low",  32'(rd_cnt - rd0), 32'd0);
        check("midrst_miso_low", 32'(miso), 32'd0);
        sl = 1'b1;
        wait_cyc(12);
        check("midrst_wr_hi",  32'(wr_cnt - wr0), 32'd0);
        check("midrst_err_hi", 32'(err_cnt - err0), 32'd0);
        frame_check("post_rst", 16'h0033, 16'h0001, 32, 8);

        for (int f = 0; f < 8; f++) begin
            frame_check("rand", 16'($urandom), 16'($urandom),
                        lens[$urandom_range(0, 4)], int'($urandom_range(4, 10)));
        end

        // Back-to-back frames, one-cycle chip-select gap, minimum half-bit.
        wr0 = wr_cnt; err0 = err_cnt;
        for (int f = 0; f < 10; f++) begin
            ra[f] = 16'($urandom);
            rd[f] = 16'($urandom);
            run_frame(ra[f], rd[f], 32, 4, 1, rb);
            check("b2b_readback", 32'(rb), 32'(rd_model(ra[f])));
        end
        wait_cyc(12);
        check("b2b_wr_cnt",  32'(wr_cnt - wr0), 32'd10);
        check("b2b_err_cnt", 32'(err_cnt - err0), 32'd0);
        for (int f = 0; f < 10; f++) begin
            if (wr_addr_q.size() > 0) begin
                check("b2b_addr", 32'(wr_addr_q.pop_front()), 32'(ra[f]));
                check("b2b_data", 32'(wr_data_q.pop_front()), 32'(rd[f]));
            end else begin
                check("b2b_wr_queue", 32'd0, 32'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_reg_port.md
SPI_SLAVE_REG_PORT -- requirements
Module: spi_slave_reg_port

Interface
REQ-001 Parameter LSB_FIRST, default 1, meaning bit order within each byte on MOSI/MISO (1 = LSB first).
REQ-002 Parameter SYNC_STAGES, default 2, meaning number of flops in the spi_clk/sl/mosi synchronizers.
REQ-003 clk40M  input  1  sole system clock; all logic is synchronous to it.
REQ-004 nRst  input  1  asynchronous, active-low reset.
REQ-005 spi_clk  input  1  SPI clock from master, mode 3 (idles high).
REQ-006 sl  input  1  chip select, active low, one frame per low period.
REQ-007 mosi  input  1  serial data from master.
REQ-008 miso  output  1  serial read-back data to master.
REQ-009 o_wr_en  output  1  one-cycle write strobe for a complete frame.
REQ-010 o_addr  output  16  frame address, {byte1, byte0}.
REQ-011 o_wr_data  output  16  frame data, {byte3, byte2}.
REQ-012 o_rd_req  output  1  one-cycle read request once o_addr is valid.
REQ-013 i_rd_data  input  16  register contents for o_addr, valid one cycle after o_rd_req.
REQ-014 o_frame_err  output  1  one-cycle pulse on a malformed frame.

Function
REQ-015 Frame = 32 bits while sl low: byte0 addr LSB, byte1 addr MSB, byte2 data LSB, byte3 data MSB; bits within a byte ordered per LSB_FIRST.
REQ-016 spi_clk, sl, mosi pass SYNC_STAGES flops before use; rising/falling spi_clk edges detected on synchronized value.
REQ-017 mosi sampled on detected spi_clk rising edge only while synchronized sl is low; 6-bit bit counter increments per sample.
REQ-018 States: IDLE, ADDR (bits 0-15), DATA (bits 16-31), DONE (32 bits received, wait sl high), ERR (wait sl high), WAIT_HI (post-reset, wait sl high).
REQ-019 IDLE -> ADDR on synchronized sl falling edge; bit counter cleared.
REQ-020 ADDR -> DATA on 16th sample; o_addr updated in that cycle; o_rd_req pulses the following cycle.
REQ-021 i_rd_data captured into the MISO shift register exactly one cycle after o_rd_req.
REQ-022 miso drives read-back bit k (k=0..15, order per LSB_FIRST) updated on the synchronized spi_clk falling edge preceding sample 16+k; miso = 0 in every other state.
REQ-023 DATA -> DONE on 32nd sample; o_wr_data updated and o_wr_en pulsed in the same cycle.
REQ-024 DONE -> IDLE on synchronized sl rising edge; no further strobe.
REQ-025 Any spi_clk rising edge in DONE -> ERR; no second o_wr_en.
REQ-026 sl rising while in ADDR or DATA (count < 32) -> o_frame_err pulse, no o_wr_en, return to IDLE; o_addr keeps last value.
REQ-027 ERR -> IDLE on sl rising, with o_frame_err pulsed in that cycle.
REQ-028 Correct operation is required for master half-bit periods >= 4 clk40M cycles.
REQ-029 spi_clk edges while sl high are ignored.

Reset
REQ-030 nRst low: state WAIT_HI, counter 0, miso 0, o_wr_en 0, o_rd_req 0, o_frame_err 0, o_addr 0, o_wr_data 0, synchronizers to idle values (spi_clk 1, sl 1, mosi 0).
REQ-031 Reset mid-frame discards the partial frame; WAIT_HI -> IDLE only after synchronized sl is seen high.

Structure
REQ-032 Shared package spi_pkg holds the state enum, FRAME_BITS = 32, ADDR_BITS = 16, and SPI_MODE = 3 constants.
REQ-033 One sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated for spi_clk and sl.

Verification
REQ-034 Mode-3 master, half-bit 8 cycles, frame addr 16'h00F9 data 16'hC007 -> single o_wr_en, o_addr = 16'h00F9, o_wr_data = 16'hC007, no o_frame_err.
REQ-035 i_rd_data = 16'hA5C3 for addr 16'h0030 -> miso bits 16-31 observed by master yield 16'hA5C3, LSB first.
REQ-036 sl raised after 20 bits -> o_frame_err pulse, no o_wr_en, next valid frame written correctly.
REQ-037 33 clocks in one frame -> one o_wr_en at bit 32, o_frame_err on sl rise.
REQ-038 nRst asserted at bit 10 and released with sl still low -> no strobes until sl high; next frame addr 16'h0033 data 16'h0001 written correctly.
REQ-039 Ten back-to-back frames, 1-cycle sl inactive gap at half-bit 4 -> ten o_wr_en pulses with matching addr/data.
